// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline-boundary register.
// State encoding, control-bit positions and default payload widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } pipe_state_e;

  localparam int unsigned CTRL_WMEM = 0;
  localparam int unsigned CTRL_RMEM = 1;
  localparam int unsigned CTRL_WREG = 2;
  localparam int unsigned CTRL_JMP  = 3;

  localparam int unsigned DefDataW     = 32;
  localparam int unsigned DefDestW     = 4;
  localparam int unsigned DefCtrlW     = 4;
  localparam int unsigned DefStallCntW = 16;

  function automatic int unsigned payload_w(input int unsigned data_w, input int unsigned dest_w,
                                            input int unsigned ctrl_w);
    return data_w + dest_w + ctrl_w;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready payload register with flush. Defining PIPE_STAGE_SKID_EN adds a second
// (skid) entry and makes in_ready a flop, cutting the out_ready -> in_ready path.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned PAYLOAD_W = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
);

  pipe_state_e          state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic                 valid_q, valid_d;
`ifdef PIPE_STAGE_SKID_EN
  logic [PAYLOAD_W-1:0] skid_q, skid_d;
  logic                 in_ready_q, in_ready_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      valid_q <= 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      skid_q     <= '0;
      in_ready_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      valid_q <= valid_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d  = skid_q;
`endif
    case (state_q)
      StEmpty: begin
        if (in_valid) begin
          main_d  = in_data;
          state_d = StOne;
        end
      end
      StOne: begin
        if (in_valid && out_ready) begin
          main_d = in_data;
        end else if (in_valid && !out_ready) begin
`ifdef PIPE_STAGE_SKID_EN
          skid_d  = in_data;
          state_d = StTwo;
`endif
        end else if (!in_valid && out_ready) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
`ifdef PIPE_STAGE_SKID_EN
        if (out_ready) begin
          main_d  = skid_q;
          state_d = StOne;
        end
`else
        state_d = StEmpty;
`endif
      end
      default: state_d = StEmpty;
    endcase
    // Flush wins over everything; keep stale data so nothing offered now is captured.
    if (flush) begin
      state_d = StEmpty;
      main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
      skid_d  = skid_q;
`endif
    end
  end

  always_comb begin
    valid_d = (state_d != StEmpty);
`ifdef PIPE_STAGE_SKID_EN
    in_ready_d = (state_d != StTwo);
    in_ready   = in_ready_q;
`else
    in_ready   = out_ready | ~valid_q;
`endif
    out_valid = valid_q;
    out_data  = main_q;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register: packs ALU result, destination and control into one payload,
// gates control on bubbles and counts stall cycles. Skid buffer enabled by PIPE_STAGE_SKID_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned DEST_W      = DefDestW,
  parameter int unsigned CTRL_W      = DefCtrlW,
  parameter int unsigned STALL_CNT_W = DefStallCntW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_alu_res,
  input  logic [DEST_W-1:0]      in_wr_dest,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_alu_res,
  output logic [DEST_W-1:0]      out_wr_dest,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int unsigned PayloadW = payload_w(DATA_W, DEST_W, CTRL_W);
  localparam logic [STALL_CNT_W-1:0] StallMax = '1;

  logic [PayloadW-1:0]    in_data, out_data;
  logic [CTRL_W-1:0]      ctrl_held;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign in_data = {in_ctrl, in_wr_dest, in_alu_res};

  pipe_skid_buf #(
    .PAYLOAD_W (PayloadW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  assign {ctrl_held, out_wr_dest, out_alu_res} = out_data;
  // Bubbles must never carry write or jump enables downstream.
  assign out_ctrl = out_valid ? ctrl_held : '0;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != StallMax)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
